// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single fixed-latency memory.
// Optional ARB_ROUND_ROBIN_EN macro replaces fixed data priority with round-robin.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        write_mem,
  output logic [2:0]  funct3,
  output logic [31:0] write_address,
  output logic [31:0] write_data,
  output logic [31:0] read_address,
  input  logic [31:0] read_data
);

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [2:0] F3_WORD   = 3'b010;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        owner_d;
  logic        pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;
  assign pick_d = d_req && (!if_req || !last_d);
`else
  assign pick_d = d_req;
`endif

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (pick_d) begin
            d_gnt     = 1'b1;
            state_nxt = d_we ? WRITE : READ_WAIT;
          end else if (if_req) begin
            if_gnt    = 1'b1;
            state_nxt = READ_WAIT;
          end
        end
      end
      READ_WAIT: if (cnt <= 4'd1) state_nxt = IDLE;
      WRITE:     state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= 4'd0;
      owner_d       <= 1'b0;
      read_address  <= 32'd0;
      write_address <= 32'd0;
      write_data    <= 32'd0;
      funct3        <= F3_WORD;
      write_mem     <= 1'b0;
      if_rvalid     <= 1'b0;
      d_rvalid      <= 1'b0;
      if_rdata      <= 32'd0;
      d_rdata       <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d        <= 1'b0;
`endif
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      write_mem <= 1'b0;
      if (if_gnt) begin
        read_address <= if_addr;
        funct3       <= F3_WORD;
        cnt          <= WAIT_LOAD;
        owner_d      <= 1'b0;
      end else if (d_gnt) begin
        funct3 <= d_funct3;
        if (d_we) begin
          write_address <= d_addr;
          write_data    <= d_wdata;
          write_mem     <= 1'b1;
        end else begin
          read_address <= d_addr;
          cnt          <= WAIT_LOAD;
          owner_d      <= 1'b1;
        end
      end
      // Memory data is captured on the edge where the countdown expires.
      if (state == READ_WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt <= 4'd1) begin
          if (owner_d) begin
            d_rdata  <= read_data;
            d_rvalid <= 1'b1;
          end else begin
            if_rdata  <= read_data;
            if_rvalid <= 1'b1;
          end
        end
      end
`ifdef ARB_ROUND_ROBIN_EN
      if (if_gnt || d_gnt) last_d <= d_gnt;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with WAIT_CYCLES=1, one with 3,
// sharing stimulus; default (fixed data priority) build.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, read_data;
  logic [2:0]  d_funct3;

  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, write_mem;
  logic [31:0] if_rdata, d_rdata, write_address, write_data, read_address;
  logic [2:0]  funct3;

  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_write_mem;
  logic [31:0] b_if_rdata, b_d_rdata, b_write_address, b_write_data, b_read_address;
  logic [2:0]  b_funct3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .write_mem(write_mem), .funct3(funct3), .write_address(write_address),
    .write_data(write_data), .read_address(read_address), .read_data(read_data)
  );

  mem_arbiter #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .write_mem(b_write_mem), .funct3(b_funct3), .write_address(b_write_address),
    .write_data(b_write_data), .read_address(b_read_address), .read_data(read_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; read_data = '0; d_funct3 = 3'b000;

    // Reset state, with requests asserted while rst is high
    tick(); tick();
    if_req = 1'b1; d_req = 1'b1; #1;
    check("rst_if_gnt", if_gnt, 0);
    check("rst_d_gnt", d_gnt, 0);
    check("rst_funct3", funct3, 3'b010);
    check("rst_read_address", read_address, 0);
    check("rst_write_data", write_data, 0);
    check("rst_write_mem", write_mem, 0);
    check("rst_if_rvalid", if_rvalid, 0);
    check("rst_d_rdata", d_rdata, 0);
    if_req = 1'b0; d_req = 1'b0;

    // Fetch only, WAIT_CYCLES=1: grant T, rvalid T+2
    tick(); rst = 1'b0; if_req = 1'b1; if_addr = 32'h10; read_data = 32'h0050_0093; #1;
    check("fetch_if_gnt", if_gnt, 1);
    check("fetch_d_gnt", d_gnt, 0);
    tick();
    check("fetch_read_address", read_address, 32'h10);
    check("fetch_funct3", funct3, 3'b010);
    check("fetch_busy_if_gnt", if_gnt, 0);
    check("fetch_early_rvalid", if_rvalid, 0);
    tick(); if_req = 1'b0; #1;
    check("fetch_rvalid", if_rvalid, 1);
    check("fetch_rdata", if_rdata, 32'h0050_0093);
    tick();
    check("fetch_rvalid_pulse", if_rvalid, 0);
    check("fetch_rdata_hold", if_rdata, 32'h0050_0093);

    // Simultaneous requests: data first, fetch granted in the d_rvalid cycle
    tick();
    if_req = 1'b1; if_addr = 32'h30;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h20;
    read_data = 32'h1111_1111; #1;
    check("both_d_gnt", d_gnt, 1);
    check("both_if_gnt", if_gnt, 0);
    tick(); d_req = 1'b0; #1;
    check("both_wait_if_gnt", if_gnt, 0);
    check("both_read_address_d", read_address, 32'h20);
    tick(); read_data = 32'h2222_2222; #1;
    check("both_d_rvalid", d_rvalid, 1);
    check("both_d_rdata", d_rdata, 32'h1111_1111);
    check("both_if_gnt_in_rvalid", if_gnt, 1);
    tick(); if_req = 1'b0; #1;
    check("both_read_address_if", read_address, 32'h30);
    check("both_d_rvalid_pulse", d_rvalid, 0);
    tick();
    check("both_if_rvalid", if_rvalid, 1);
    check("both_if_rdata", if_rdata, 32'h2222_2222);
    check("both_d_rdata_hold", d_rdata, 32'h1111_1111);

    // Store: write_mem for exactly one cycle, no d_rvalid
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_funct3 = 3'b010; #1;
    check("store_d_gnt", d_gnt, 1);
    check("store_write_mem_pre", write_mem, 0);
    tick(); d_req = 1'b0; #1;
    check("store_write_mem", write_mem, 1);
    check("store_write_address", write_address, 32'h40);
    check("store_write_data", write_data, 32'hDEAD_BEEF);
    check("store_d_rvalid", d_rvalid, 0);
    tick();
    check("store_write_mem_off", write_mem, 0);
    check("store_d_rvalid_after", d_rvalid, 0);
    check("store_write_data_hold", write_data, 32'hDEAD_BEEF);
    tick();
    check("store_no_rvalid_late", d_rvalid, 0);

    // Byte load on the WAIT_CYCLES=3 instance: d_rvalid 4 cycles after d_gnt
    rst = 1'b1; d_we = 1'b0;
    tick(); rst = 1'b0;
    d_req = 1'b1; d_funct3 = 3'b000; d_addr = 32'h44;
    if_req = 1'b1; if_addr = 32'h80; read_data = 32'hCAFE_F00D; #1;
    check("load3_d_gnt", b_d_gnt, 1);
    check("load3_if_gnt_grant", b_if_gnt, 0);
    tick(); d_req = 1'b0; #1;
    check("load3_funct3", b_funct3, 3'b000);
    check("load3_read_address", b_read_address, 32'h44);
    check("load3_if_gnt_w1", b_if_gnt, 0);
    check("load3_d_rvalid_w1", b_d_rvalid, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("load3_if_gnt_wait", b_if_gnt, 0);
      check("load3_d_rvalid_wait", b_d_rvalid, 0);
    end
    tick();
    check("load3_d_rvalid", b_d_rvalid, 1);
    check("load3_d_rdata", b_d_rdata, 32'hCAFE_F00D);
    check("load3_if_gnt_in_rvalid", b_if_gnt, 1);

    // Reset during READ_WAIT abandons the fetch; a fresh fetch follows
    tick();
    check("abort_read_address", b_read_address, 32'h80);
    check("abort_funct3", b_funct3, 3'b010);
    check("abort_busy_if_gnt", b_if_gnt, 0);
    tick(); rst = 1'b1; #1;
    check("abort_rst_if_gnt", b_if_gnt, 0);
    tick(); rst = 1'b0; if_addr = 32'h90; #1;
    check("abort_read_address_rst", b_read_address, 0);
    check("abort_funct3_rst", b_funct3, 3'b010);
    check("abort_if_rvalid_rst", b_if_rvalid, 0);
    check("abort_new_if_gnt", b_if_gnt, 1);
    tick(); if_req = 1'b0; #1;
    check("abort_no_stale_rvalid", b_if_rvalid, 0);
    check("abort_new_read_address", b_read_address, 32'h90);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("abort_new_wait_rvalid", b_if_rvalid, 0);
    end
    tick();
    check("abort_new_if_rvalid", b_if_rvalid, 1);
    check("abort_new_if_rdata", b_if_rdata, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
